// File: rtl/cla_adder_16b_reg.sv
// 16-bit two-level carry-lookahead adder with a registered {cout,s}.
// Four 4-bit lookahead groups feed one second-level lookahead unit.

module cla_group4 (
   input  logic [3:0] p,
   input  logic [3:0] g,
   input  logic       ci,
   output logic [3:0] c,
   output logic       pg,
   output logic       gg
);
   // Every in-group carry is a flat sum of products, so there is no ripple inside the group
   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
   assign pg   = &p;
   assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module cla_adder_16b_reg #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);
   localparam int NGRP = WIDTH / GROUP;

   logic [NGRP-1:0][GROUP-1:0] p, g, c;
   logic [NGRP-1:0]            pg, gg;
   logic [NGRP:0]              gc;
   logic [WIDTH-1:0]           s_next;

   assign p = a ^ b;
   assign g = a & b;

   // Second-level lookahead: group carries formed directly from cin, not chained
   assign gc[0] = cin;
   assign gc[1] = gg[0] | (pg[0] & cin);
   assign gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
   assign gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
                | (pg[2] & pg[1] & pg[0] & cin);
   assign gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
                | (pg[3] & pg[2] & pg[1] & gg[0]) | (pg[3] & pg[2] & pg[1] & pg[0] & cin);

   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      cla_group4 u_grp (
         .p  (p[k]),
         .g  (g[k]),
         .ci (gc[k]),
         .c  (c[k]),
         .pg (pg[k]),
         .gg (gg[k])
      );
   end

   assign s_next = p ^ c;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s    <= '0;
         cout <= 1'b0;
      end else begin
         s    <= s_next;
         cout <= gc[NGRP];
      end
   end
endmodule

// File: tb/tb_cla_adder_16b_reg.sv
// Randomized self-checking bench for cla_adder_16b_reg against a plain-arithmetic model.

module tb_cla_adder_16b_reg;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] a, b, s;
   logic        cin, cout;

   int checks = 0;
   int errors = 0;
   logic [16:0] prev_exp;
   bit          have_prev = 0;

   cla_adder_16b_reg dut (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .s    (s),
      .cout (cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %05h expected %05h", tag, got, exp);
      end
   endtask

   // Drive one vector at the falling edge, confirm outputs hold until the clock, then check the result
   task automatic apply(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic vr);
      logic [16:0] exp;
      @(negedge clk);
      a = va; b = vb; cin = vc; rst_n = vr;
      exp = vr ? ({1'b0, va} + {1'b0, vb} + {16'b0, vc}) : 17'h0;
      #1;
      if (have_prev) chk({tag, "_hold"}, {cout, s}, prev_exp);
      @(posedge clk);
      #1;
      chk(tag, {cout, s}, exp);
      prev_exp  = exp;
      have_prev = 1;
   endtask

   initial begin
      a = '0; b = '0; cin = 0; rst_n = 0;
      apply("rst0", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      apply("rst1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      apply("zero", 16'h0000, 16'h0000, 1'b0, 1'b1);
      apply("1234p4321", 16'h1234, 16'h4321, 1'b0, 1'b1);
      apply("ffffp1", 16'hFFFF, 16'h0001, 1'b0, 1'b1);
      apply("full_chain", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      apply("ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b1);
      apply("grp0", 16'h000F, 16'h0001, 1'b0, 1'b1);
      apply("grp2", 16'h0FFF, 16'h0001, 1'b0, 1'b1);
      apply("msb", 16'h8000, 16'h8000, 1'b0, 1'b1);
      apply("grp1", 16'h00FF, 16'h0000, 1'b1, 1'b1);
      apply("rst_mid", 16'h1234, 16'h5678, 1'b1, 1'b0);
      apply("after_rst", 16'hABCD, 16'h1111, 1'b1, 1'b1);
      for (int i = 0; i < 20000; i++) begin
         apply("rand", 16'($urandom), 16'($urandom), 1'($urandom),
               ($urandom_range(0, 63) != 0));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
